// File: rtl/acc_12b.sv
// Burst accumulator: sums 1..2^LEN_W unsigned 12-bit samples through a 12-bit
// adder, counting carry-outs so {carries, acc} is the exact total.

module adder_12b (
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic        cin,
  output logic [11:0] s,
  output logic        co
);
  assign {co, s} = {1'b0, x} + {1'b0, y} + {12'd0, cin};
endmodule

module acc_12b #(
  parameter int LEN_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic                in_valid,
  input  logic [11:0]         in_data,
  output logic                in_ready,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [11:0]         out_sum,
  output logic [LEN_W-1:0]    out_carries,
  output logic [LEN_W+11:0]   out_total
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  state_e           state_q, state_d;
  logic [11:0]      acc_q, acc_d;
  logic [LEN_W-1:0] carries_q, carries_d;
  logic [LEN_W:0]   remaining_q, remaining_d;

  logic [11:0]      add_s;
  logic             add_co;

  adder_12b u_adder (
    .x   (acc_q),
    .y   (in_data),
    .cin (1'b0),
    .s   (add_s),
    .co  (add_co)
  );

  // NOTE: every variable gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carries_d   = carries_q;
    remaining_d = remaining_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d       = '0;
          carries_d   = '0;
          // len == 0 encodes a full 2^LEN_W-sample burst
          remaining_d = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
          state_d     = ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_d       = add_s;
          // At most 2^LEN_W - 1 carries fit in a full burst, so no wrap.
          carries_d   = carries_q + {{(LEN_W-1){1'b0}}, add_co};
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == 1) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      carries_q   <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carries_q   <= carries_d;
      remaining_q <= remaining_d;
    end
  end

  assign in_ready    = (state_q == ACC);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign out_sum     = acc_q;
  assign out_carries = carries_q;
  assign out_total   = {carries_q, acc_q};

endmodule

// File: tb/tb_acc_12b.sv
// Self-checking bench for acc_12b: directed scenarios plus randomized bursts
// checked against an arithmetic sum of the driven samples.

module tb_acc_12b;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  len;
  logic        in_valid;
  logic [11:0] in_data;
  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic [3:0]  out_carries;
  logic [15:0] out_total;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] stim_q[$];

  acc_12b #(.LEN_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carries (out_carries),
    .out_total   (out_total)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exact total of the queued samples.
  function automatic logic [15:0] model_total();
    int sum = 0;
    foreach (stim_q[i]) sum += int'(stim_q[i]);
    return 16'(sum);
  endfunction

  // Starts a burst, feeds stim_q with `gap` idle cycles before each sample
  // (garbage on in_data during gaps), and returns right after the last accept.
  task automatic drive_burst(input logic [3:0] l, input int gap,
                             output int accepts, output logic ready_after_start);
    int budget;
    accepts = 0;
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    len   = 4'($urandom);
    ready_after_start = in_ready;
    foreach (stim_q[i]) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data  = 12'hABC;
        tick();
      end
      in_valid = 1'b1;
      in_data  = stim_q[i];
      budget   = 0;
      while (!in_ready && budget < 50) begin
        tick();
        budget++;
      end
      if (in_ready) accepts++;
      tick();
    end
    in_valid = 1'b0;
    in_data  = 12'hABC;
  endtask

  task automatic consume_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    n_checks++;
    if ({in_ready, busy, out_valid, out_sum, out_carries, out_total} !== '0)
      $display("FAIL reset_outputs: got rdy=%b busy=%b ov=%b total=%h want all zero",
               in_ready, busy, out_valid, out_total);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++;
    if ({in_ready, busy, out_valid} !== 3'b000)
      $display("FAIL reset_release_idle: got %b want 000", {in_ready, busy, out_valid});
    else n_pass++;
  endtask

  task automatic test_basic();
    int acc_n; logic r;
    stim_q = '{12'd1, 12'd2, 12'd3};
    drive_burst(4'd3, 0, acc_n, r);
    n_checks++;
    if (r !== 1'b1) $display("FAIL basic_ready_after_start: got %b want 1", r); else n_pass++;
    n_checks++;
    if (acc_n !== 3) $display("FAIL basic_accepts: got %0d want 3", acc_n); else n_pass++;
    n_checks++;
    if ({out_valid, in_ready, busy} !== 3'b101)
      $display("FAIL basic_done_flags: got %b want 101", {out_valid, in_ready, busy});
    else n_pass++;
    n_checks++;
    if ({out_total, out_sum, out_carries} !== {model_total(), 12'h006, 4'h0})
      $display("FAIL basic_result: got total=%h sum=%h car=%h want 0006/006/0",
               out_total, out_sum, out_carries);
    else n_pass++;
    consume_result();
    n_checks++;
    if ({busy, out_valid, in_ready} !== 3'b000)
      $display("FAIL basic_back_to_idle: got %b want 000", {busy, out_valid, in_ready});
    else n_pass++;
  endtask

  task automatic test_full();
    int acc_n = 0;
    start = 1'b1; len = 4'd0;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 12'hFFF;
    for (int c = 0; c < 20; c++) begin
      if (in_valid && in_ready) acc_n++;
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (acc_n !== 16) $display("FAIL full_accepts: got %0d want 16", acc_n); else n_pass++;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b01)
      $display("FAIL full_flags: got rdy=%b ov=%b want 0/1", in_ready, out_valid);
    else n_pass++;
    n_checks++;
    if ({out_total, out_sum, out_carries} !== {16'(16 * 4095), 12'hFF0, 4'hF})
      $display("FAIL full_result: got total=%h sum=%h car=%h want FFF0/FF0/F",
               out_total, out_sum, out_carries);
    else n_pass++;
    consume_result();
  endtask

  task automatic test_carry();
    int acc_n; logic r;
    logic [11:0] pairs [2][2];
    pairs[0] = '{12'h800, 12'h800};
    pairs[1] = '{12'hFFF, 12'h001};
    for (int k = 0; k < 2; k++) begin
      stim_q = '{pairs[k][0], pairs[k][1]};
      drive_burst(4'd2, 0, acc_n, r);
      n_checks++;
      if ({out_valid, out_total, out_sum, out_carries} !== {1'b1, model_total(), 12'h000, 4'h1})
        $display("FAIL carry_case%0d: got ov=%b total=%h sum=%h car=%h want 1/1000/000/1",
                 k, out_valid, out_total, out_sum, out_carries);
      else n_pass++;
      consume_result();
    end
  endtask

  task automatic test_stall_hold();
    int acc_n; logic r;
    logic [15:0] exp;
    stim_q = '{12'd10, 12'd20, 12'd30, 12'd40};
    exp = model_total();
    drive_burst(4'd4, 2, acc_n, r);
    n_checks++;
    if (acc_n !== 4) $display("FAIL stall_accepts: got %0d want 4", acc_n); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({out_valid, out_total} !== {1'b1, exp} || exp !== 16'd100)
        $display("FAIL stall_hold_cycle%0d: got ov=%b total=%0d want 1/100", c, out_valid, out_total);
      else n_pass++;
      tick();
    end
    consume_result();
    n_checks++;
    if ({busy, out_valid, out_total} !== {2'b00, exp})
      $display("FAIL stall_idle_after_ready: got busy=%b ov=%b total=%0d want 0/0/100",
               busy, out_valid, out_total);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    logic [15:0] exp;
    stim_q.delete();
    for (int i = 0; i < 5; i++) stim_q.push_back(12'($urandom));
    exp = model_total();
    start = 1'b1; len = 4'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b0; start = 1'b1; len = 4'd2;
        tick();
        start = 1'b0;
      end
      in_valid = 1'b1; in_data = stim_q[i];
      tick();
    end
    in_valid = 1'b0;
    start = 1'b1; len = 4'd1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, out_total} !== {2'b10, exp})
      $display("FAIL start_ignored: got ov=%b rdy=%b total=%h want 1/0/%h",
               out_valid, in_ready, out_total, exp);
    else n_pass++;
    consume_result();
  endtask

  task automatic test_reset_mid();
    int acc_n; logic r;
    start = 1'b1; len = 4'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 12'h321;
      tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, busy, out_valid, out_sum, out_carries, out_total} !== '0)
      $display("FAIL reset_mid_outputs: got rdy=%b busy=%b ov=%b total=%h want all zero",
               in_ready, busy, out_valid, out_total);
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    stim_q = '{12'd5};
    drive_burst(4'd1, 0, acc_n, r);
    n_checks++;
    if ({out_valid, out_total, out_carries} !== {1'b1, model_total(), 4'h0} || model_total() !== 16'h0005)
      $display("FAIL reset_mid_recover: got ov=%b total=%h car=%h want 1/0005/0",
               out_valid, out_total, out_carries);
    else n_pass++;
    consume_result();
  endtask

  task automatic test_random();
    int acc_n, n, gap, wait_c;
    logic r;
    logic [3:0] l;
    for (int it = 0; it < 25; it++) begin
      l = 4'($urandom_range(0, 15));
      n = (l == 0) ? 16 : int'(l);
      gap = $urandom_range(0, 2);
      stim_q.delete();
      for (int i = 0; i < n; i++)
        stim_q.push_back((it % 4 == 0) ? 12'($urandom_range(3800, 4095)) : 12'($urandom));
      drive_burst(l, gap, acc_n, r);
      n_checks++;
      if (acc_n !== n || out_valid !== 1'b1 || out_total !== model_total())
        $display("FAIL random_burst%0d: got acc=%0d ov=%b total=%h want %0d/1/%h",
                 it, acc_n, out_valid, out_total, n, model_total());
      else n_pass++;
      wait_c = $urandom_range(0, 3);
      for (int c = 0; c < wait_c; c++) tick();
      consume_result();
      n_checks++;
      if ({busy, out_valid} !== 2'b00)
        $display("FAIL random_idle%0d: got busy=%b ov=%b want 0/0", it, busy, out_valid);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_carry();
    test_stall_hold();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/acc_12b.md
# acc_12b

Sequential burst accumulator that sums 1–16 unsigned 12-bit samples, one per accepted handshake, using an `adder_12b` instance as its datapath adder. It sits directly upstream of the adder:
- it drives X, Y and Cin from its accumulator register and the incoming sample;
- it consumes S and Co on every accept.

The result is an exact 16-bit total: a 12-bit low sum plus a 4-bit count of adder carry-outs. A valid/ready handshake returns it to the consumer.

## Interface
- `LEN_W`, default 4: width of the burst-length field. A `len` value of 0 encodes a burst of 2^LEN_W samples. Fixed at 4 for the 16-bit total.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a burst. Sampled only in IDLE.
- `len`  in  LEN_W  burst length, latched when `start` is accepted. 1..15 means that many samples; 0 means 16.
- `in_valid`  in  1  sample present on `in_data`.
- `in_data`  in  12  unsigned sample.
- `in_ready`  out  1  block accepts a sample this cycle.
- `busy`  out  1  high in ACC and DONE.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  12  low 12 bits of the total (accumulator register).
- `out_carries`  out  4  number of adder carry-outs seen in the burst.
- `out_total`  out  16  `{out_carries, out_sum}`.

## Operation
- Datapath:
  - `adder_12b` inputs are X = acc, Y = `in_data`, Cin = 0.
  - On each accept (`in_valid && in_ready`): acc <= S, and carries <= carries + Co.
  - Carries never exceed 15 for 16 samples of at most 0xFFF, so no saturation is needed. `out_total` equals the exact arithmetic sum.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - Outputs: `in_ready`=0, `out_valid`=0, `busy`=0.
  - On `start`=1: clear acc and carries, load remaining <= (`len`==0 ? 16 : `len`), go to ACC.
- ACC:
  - Outputs: `in_ready`=1, `busy`=1.
  - Each accept decrements remaining.
  - An accept with remaining==1 goes to DONE in the same edge.
  - `in_valid`=0 cycles stall without changing state.
- DONE:
  - Outputs: `out_valid`=1, `in_ready`=0.
  - `out_sum`, `out_carries` and `out_total` are held stable.
  - On `out_ready`=1: go to IDLE. acc and carries keep their value until the next `start`.
- `start` in ACC or DONE is ignored. `len` is not re-sampled.
- `in_data` outside accept cycles is ignored. `in_valid` in IDLE or DONE is not accepted.
- Outputs are register-driven (state and acc/carries registers); `in_ready` and `out_valid` are decoded from state only. Neither depends combinationally on `in_valid` or `out_ready`.

## Timing
- Reset (asynchronous, immediate): state=IDLE, acc=0, carries=0, remaining=0.
  - Resulting outputs: `in_ready`=0, `busy`=0, `out_valid`=0, `out_sum`=0, `out_carries`=0, `out_total`=0.
- Reset mid-burst aborts the burst. No partial result is ever presented.
- `start` sampled at edge t: `in_ready`=1 during cycle t+1.
- Throughput: one sample per cycle with `in_valid` held high. An N-sample burst completes N edges after the first accept opportunity.
- Last accept at edge e: `out_valid`=1 in cycle e+1 with the final total. Latency from last sample to result is 1 cycle.
- `out_valid && out_ready` at edge d: IDLE in cycle d+1. The earliest new `start` is sampled at edge d+1, so there is one bubble cycle between bursts.
- The adder path (X/Y to S/Co) must close within one clock period; no adder pipelining.

## Test plan
- `len`=3; samples 1, 2, 3 back-to-back → `out_valid` one cycle after third accept; `out_sum`=0x006, `out_carries`=0, `out_total`=0x0006.
- `len`=0; 16 samples of 0xFFF → exactly 16 accepts, then `in_ready`=0; `out_sum`=0xFF0, `out_carries`=0xF, `out_total`=0xFFF0.
- `len`=2; samples 0x800, 0x800 → `out_sum`=0x000, `out_carries`=1, `out_total`=0x1000. Also `len`=2; samples 0xFFF, 0x001 → `out_total`=0x1000.
- `len`=4; samples 10, 20, 30, 40 with `in_valid` gaps of 2 cycles between each, and garbage `in_data` (0xABC) during gaps; hold `out_ready`=0 for 5 cycles → `out_total`=100 stable all 5 cycles; IDLE one cycle after `out_ready`=1.
- `len`=5; pulse `start` again during ACC and during DONE → both ignored; result equals the sum of the 5 samples only.
- `len`=4; assert `rst` after 2 accepts → all outputs 0 immediately, `busy`=0. Then `len`=1, sample 5 → `out_total`=0x0005, `out_carries`=0.
